moving_avg_mc: RTL

MOVING_AVG_MC -- requirements
Module: moving_avg_mc

---
 rtl/moving_avg_mc.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/moving_avg_mc.sv
// moving_avg_mc -- multi-channel power-of-two boxcar moving average.
//
// Purpose: keeps a running sum per channel over the last 2^k accepted
// samples. All channels share one valid strobe. The output is the sum
// arithmetically shifted right by k.
//
// Optional feature: define MOVING_AVG_ROUND_EN to round half up,
// (sum + 2^(k-1)) >>> k. Without it the result is the floor shift.
//
// Ports:
//   clk_in         : the only clock; all logic runs on its rising edge
//   rst_in         : synchronous active-high reset; k returns to MAX_WINDOW_SHIFT
//   data_in        : NUM_CHANNELS signed samples; channel c is at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_in_valid  : the samples on data_in are accepted this cycle
//   win_shift_in   : requested window log2; sampled only while clear_in is high
//   clear_in       : restarts averaging and latches min(win_shift_in, MAX_WINDOW_SHIFT)
//   data_out       : signed averages, packed the same way as data_in
//   data_out_valid : one-cycle strobe marking a new data_out
//   fill_count     : samples held in the current window, saturating at 2^k
//
// Handshake: there is no back-pressure. A sample is taken on every rising
// edge where data_in_valid is high and clear_in and rst_in are low.
// data_out_valid is high for exactly one cycle, one cycle after an accepted
// sample that leaves the window full. data_out holds its value between strobes.
module moving_avg_mc #(
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_CHANNELS     = 2,
  parameter int MAX_WINDOW_SHIFT = 6
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                               data_in_valid,
  input  logic [$clog2(MAX_WINDOW_SHIFT+1)-1:0] win_shift_in,
  input  logic                               clear_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                               data_out_valid,
  output logic [MAX_WINDOW_SHIFT:0]          fill_count
);

  localparam int KW    = $clog2(MAX_WINDOW_SHIFT + 1);
  localparam int PW    = MAX_WINDOW_SHIFT;
  localparam int DEPTH = 1 << MAX_WINDOW_SHIFT;
  localparam int FW    = MAX_WINDOW_SHIFT + 1;
  // The sum of 2^MAX_WINDOW_SHIFT samples needs MAX_WINDOW_SHIFT extra bits.
  localparam int SW    = DATA_WIDTH + MAX_WINDOW_SHIFT;

  logic [KW-1:0]                       k_q, k_d;
  logic [PW-1:0]                       wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]                       fill_q, fill_d;
  logic signed [SW-1:0]                sum_q [NUM_CHANNELS];
  logic signed [SW-1:0]                sum_d [NUM_CHANNELS];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                                valid_q, valid_d;

  // Sample history. It has no reset: an entry is read only after it has been
  // rewritten inside the current window.
  logic signed [DATA_WIDTH-1:0]        buf_mem [NUM_CHANNELS][DEPTH];

  logic [FW-1:0]                       win_len;
  logic                                full;
  logic [PW-1:0]                       rd_ptr;
  logic                                accept;
  logic signed [SW-1:0]                samp_ext, old_ext, new_sum;
`ifdef MOVING_AVG_ROUND_EN
  logic signed [SW:0]                  rnd_sum;
`endif

  always_comb begin
    win_len = FW'(1) << k_q;
    full    = (fill_q == win_len);
    // When k is the maximum, 2^k equals the buffer depth and rd_ptr equals
    // wr_ptr. The oldest entry is read in the same cycle it is overwritten.
    rd_ptr  = wr_ptr_q - win_len[PW-1:0];
    accept  = data_in_valid && !clear_in;

    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    samp_ext = '0;
    old_ext  = '0;
    new_sum  = '0;
`ifdef MOVING_AVG_ROUND_EN
    rnd_sum  = '0;
`endif

    if (clear_in) begin
      for (int c = 0; c < NUM_CHANNELS; c++) sum_d[c] = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      k_d      = (win_shift_in > KW'(MAX_WINDOW_SHIFT)) ? KW'(MAX_WINDOW_SHIFT)
                                                        : win_shift_in;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      fill_d   = full ? fill_q : fill_q + 1'b1;
      valid_d  = (fill_d == win_len);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        samp_ext = SW'(signed'(data_in[c*DATA_WIDTH +: DATA_WIDTH]));
        old_ext  = full ? SW'(buf_mem[c][rd_ptr]) : '0;
        new_sum  = sum_q[c] + samp_ext - old_ext;
        sum_d[c] = new_sum;
        if (valid_d) begin
`ifdef MOVING_AVG_ROUND_EN
          // (1 << k) >> 1 is 2^(k-1) for k >= 1 and 0 for k = 0.
          rnd_sum = {new_sum[SW-1], new_sum} + (((SW+1)'(1) << k_q) >> 1);
          dout_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rnd_sum >>> k_q);
`else
          dout_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(new_sum >>> k_q);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      k_q      <= KW'(MAX_WINDOW_SHIFT);
      wr_ptr_q <= '0;
      fill_q   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) sum_q[c] <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && accept) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        buf_mem[c][wr_ptr_q] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;
  assign fill_count     = fill_q;

endmodule
